// File: rtl/pkt_tx_seq.sv
// Packet transmit sequencer: turns a beat stream into head/body/tail flit requests for a packet processor.
// Optional protocol checking (in_first inside a packet) is enabled by defining PKT_TX_SEQ_ERR_CHK_EN.

package pkt_tx_seq_pkg;
    localparam int FLIT_DATA_DEF = 32;
    localparam int PKT_WIDTH_DEF = 8;
    localparam int NUM_VC_DEF    = 2;
    localparam int VC_W_DEF      = (NUM_VC_DEF > 1) ? $clog2(NUM_VC_DEF) : 1;

    typedef struct packed {
        logic                     valid;
        logic                     req_new;
        logic                     req_last;
        logic [PKT_WIDTH_DEF-1:0] pkt_sz;
        logic [FLIT_DATA_DEF-1:0] flit_data;
        logic [VC_W_DEF-1:0]      vc_id;
    } s_pkt_out_req_t;

    typedef struct packed {
        logic ready;
    } s_pkt_out_resp_t;
endpackage

module pkt_tx_seq
    import pkt_tx_seq_pkg::*;
#(
    parameter int FLIT_DATA = FLIT_DATA_DEF,
    parameter int PKT_WIDTH = PKT_WIDTH_DEF,
    parameter int NUM_VC    = NUM_VC_DEF,
    localparam int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                 clk_axi,
    input  logic                 arst_axi,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLIT_DATA-1:0] in_data,
    input  logic                 in_first,
    input  logic [PKT_WIDTH-1:0] in_pkt_sz,
    input  logic [VC_W-1:0]      in_vc,
    output s_pkt_out_req_t       pkt_out_req,
    input  s_pkt_out_resp_t      pkt_out_resp,
    output logic                 seq_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    localparam logic [PKT_WIDTH-1:0] SZ_ZERO = {PKT_WIDTH{1'b0}};
    localparam logic [PKT_WIDTH-1:0] SZ_ONE  = {{(PKT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [VC_W-1:0]      VC_ZERO = {VC_W{1'b0}};
    localparam s_pkt_out_req_t REQ_IDLE = '{
        valid:     1'b0,
        req_new:   1'b0,
        req_last:  1'b0,
        pkt_sz:    {PKT_WIDTH_DEF{1'b0}},
        flit_data: {FLIT_DATA_DEF{1'b0}},
        vc_id:     {VC_W_DEF{1'b0}}
    };

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PKT_WIDTH-1:0] rem_r;
    logic [PKT_WIDTH-1:0] rem_nxt_s;
    logic [PKT_WIDTH-1:0] sz_r;
    logic [PKT_WIDTH-1:0] sz_nxt_s;
    logic [PKT_WIDTH-1:0] eff_sz_s;
    logic [VC_W-1:0]      vc_r;
    logic [VC_W-1:0]      vc_nxt_s;
    s_pkt_out_req_t       req_r;
    s_pkt_out_req_t       req_nxt_s;
    logic                 seq_err_r;
    logic                 seq_err_nxt_s;
    logic                 accept_s;
    logic                 restart_s;
    logic                 head_s;

    // The output stage frees up whenever it is empty or being drained this cycle.
    assign in_ready    = !req_r.valid || pkt_out_resp.ready;
    assign accept_s    = in_valid && in_ready;
    assign eff_sz_s    = (in_pkt_sz == SZ_ZERO) ? SZ_ONE : in_pkt_sz;
    assign pkt_out_req = req_r;
    assign seq_err     = seq_err_r;

`ifdef PKT_TX_SEQ_ERR_CHK_EN
    assign restart_s = (state_r == ST_BODY) && in_first;
`else
    logic unused_first_s;
    assign restart_s      = 1'b0;
    assign unused_first_s = in_first;
`endif

    // A truncating in_first is handled exactly like a head taken from IDLE.
    assign head_s = (state_r == ST_IDLE) || restart_s;

    // Next-state, remaining-flit counter and output-stage load/hold/drain.
    always_comb begin
        state_nxt_s   = state_r;
        rem_nxt_s     = rem_r;
        sz_nxt_s      = sz_r;
        vc_nxt_s      = vc_r;
        req_nxt_s     = req_r;
        seq_err_nxt_s = 1'b0;

        if (accept_s) begin
            req_nxt_s.valid     = 1'b1;
            req_nxt_s.flit_data = in_data;
            if (head_s) begin
                rem_nxt_s          = eff_sz_s - SZ_ONE;
                sz_nxt_s           = eff_sz_s;
                vc_nxt_s           = in_vc;
                req_nxt_s.req_new  = 1'b1;
                req_nxt_s.req_last = (eff_sz_s == SZ_ONE);
                req_nxt_s.pkt_sz   = eff_sz_s;
                req_nxt_s.vc_id    = in_vc;
                seq_err_nxt_s      = restart_s;
                if (eff_sz_s == SZ_ONE) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BODY;
                end
            end else begin
                rem_nxt_s          = rem_r - SZ_ONE;
                req_nxt_s.req_new  = 1'b0;
                req_nxt_s.req_last = (rem_r == SZ_ONE);
                req_nxt_s.pkt_sz   = sz_r;
                req_nxt_s.vc_id    = vc_r;
                if (rem_r == SZ_ONE) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BODY;
                end
            end
        end else if (pkt_out_resp.ready) begin
            req_nxt_s.valid = 1'b0;
        end else begin
            req_nxt_s = req_r;
        end
    end

    // State and output registers; reset discards any partial packet.
    always_ff @(posedge clk_axi or negedge arst_axi) begin
        if (!arst_axi) begin
            state_r   <= ST_IDLE;
            rem_r     <= SZ_ZERO;
            sz_r      <= SZ_ZERO;
            vc_r      <= VC_ZERO;
            req_r     <= REQ_IDLE;
            seq_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rem_r     <= rem_nxt_s;
            sz_r      <= sz_nxt_s;
            vc_r      <= vc_nxt_s;
            req_r     <= req_nxt_s;
            seq_err_r <= seq_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_pkt_tx_seq.sv
// Directed self-checking bench for pkt_tx_seq; expectations follow PKT_TX_SEQ_ERR_CHK_EN when defined.

module tb_pkt_tx_seq;
    import pkt_tx_seq_pkg::*;

    logic            clk_axi   = 1'b0;
    logic            arst_axi  = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_first  = 1'b0;
    logic [31:0]     in_data   = 32'h0;
    logic [7:0]      in_pkt_sz = 8'h0;
    logic [0:0]      in_vc     = 1'b0;
    logic            in_ready;
    logic            seq_err;
    s_pkt_out_req_t  pkt_out_req;
    s_pkt_out_resp_t pkt_out_resp;

    int vectors     = 0;
    int miscompares = 0;

    pkt_tx_seq dut (
        .clk_axi     (clk_axi),
        .arst_axi    (arst_axi),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_first    (in_first),
        .in_pkt_sz   (in_pkt_sz),
        .in_vc       (in_vc),
        .pkt_out_req (pkt_out_req),
        .pkt_out_resp(pkt_out_resp),
        .seq_err     (seq_err)
    );

    always #5 clk_axi = ~clk_axi;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic s_pkt_out_req_t flit(input logic n, input logic l, input logic [7:0] sz,
                                            input logic [31:0] d, input logic vc);
        s_pkt_out_req_t r;
        r.valid     = 1'b1;
        r.req_new   = n;
        r.req_last  = l;
        r.pkt_sz    = sz;
        r.flit_data = d;
        r.vc_id     = vc;
        return r;
    endfunction

    task automatic chk_out(input string tag, input s_pkt_out_req_t e);
        check(tag, 64'(pkt_out_req), 64'(e));
    endtask

    task automatic tick();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic send(input logic first, input logic [7:0] sz, input logic vc, input logic [31:0] d);
        in_valid  = 1'b1;
        in_first  = first;
        in_pkt_sz = sz;
        in_vc     = vc;
        in_data   = d;
        tick();
    endtask

    initial begin
        pkt_out_resp.ready = 1'b1;

        // reset state
        #2;
        check("rst_req", 64'(pkt_out_req), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_seq_err", 64'(seq_err), 64'h0);
        @(negedge clk_axi);
        arst_axi = 1'b1;
        tick();
        check("idle_valid", 64'(pkt_out_req.valid), 64'h0);

        // sz=3 vc=1; in_vc/in_pkt_sz on body beats must be ignored
        send(1'b1, 8'd3, 1'b1, 32'hA);
        chk_out("t1_head", flit(1'b1, 1'b0, 8'd3, 32'hA, 1'b1));
        send(1'b0, 8'd7, 1'b0, 32'hB);
        chk_out("t1_body", flit(1'b0, 1'b0, 8'd3, 32'hB, 1'b1));
        send(1'b0, 8'd5, 1'b0, 32'hC);
        chk_out("t1_tail", flit(1'b0, 1'b1, 8'd3, 32'hC, 1'b1));
        in_valid = 1'b0;
        tick();
        check("t1_drain", 64'(pkt_out_req.valid), 64'h0);

        // single-flit packets: sz=1, then sz=0 with in_first low (IDLE beat is a head)
        send(1'b1, 8'd1, 1'b0, 32'hD1);
        chk_out("t2_sz1", flit(1'b1, 1'b1, 8'd1, 32'hD1, 1'b0));
        send(1'b0, 8'd0, 1'b1, 32'hD2);
        chk_out("t2_sz0", flit(1'b1, 1'b1, 8'd1, 32'hD2, 1'b1));

        // stall 4 cycles mid-packet
        send(1'b1, 8'd4, 1'b1, 32'h10);
        chk_out("t3_head", flit(1'b1, 1'b0, 8'd4, 32'h10, 1'b1));
        pkt_out_resp.ready = 1'b0;
        in_valid = 1'b1;
        in_first = 1'b0;
        in_data  = 32'h11;
        #1;
        check("t3_in_ready_lo", 64'(in_ready), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("t3_hold", flit(1'b1, 1'b0, 8'd4, 32'h10, 1'b1));
            check("t3_hold_ready", 64'(in_ready), 64'h0);
        end
        pkt_out_resp.ready = 1'b1;
        #1;
        check("t3_in_ready_hi", 64'(in_ready), 64'h1);
        tick();
        chk_out("t3_b11", flit(1'b0, 1'b0, 8'd4, 32'h11, 1'b1));
        send(1'b0, 8'd4, 1'b1, 32'h12);
        chk_out("t3_b12", flit(1'b0, 1'b0, 8'd4, 32'h12, 1'b1));
        send(1'b0, 8'd4, 1'b1, 32'h13);
        chk_out("t3_tail", flit(1'b0, 1'b1, 8'd4, 32'h13, 1'b1));

        // back-to-back sz=2 packets, no bubble
        send(1'b1, 8'd2, 1'b0, 32'h20);
        chk_out("t4_h1", flit(1'b1, 1'b0, 8'd2, 32'h20, 1'b0));
        send(1'b0, 8'd2, 1'b0, 32'h21);
        chk_out("t4_t1", flit(1'b0, 1'b1, 8'd2, 32'h21, 1'b0));
        send(1'b1, 8'd2, 1'b1, 32'h30);
        chk_out("t4_h2", flit(1'b1, 1'b0, 8'd2, 32'h30, 1'b1));
        send(1'b0, 8'd2, 1'b1, 32'h31);
        chk_out("t4_t2", flit(1'b0, 1'b1, 8'd2, 32'h31, 1'b1));

        // asynchronous reset after 2nd of 4 flits
        send(1'b1, 8'd4, 1'b0, 32'h40);
        send(1'b0, 8'd4, 1'b0, 32'h41);
        chk_out("t5_b41", flit(1'b0, 1'b0, 8'd4, 32'h41, 1'b0));
        in_valid = 1'b0;
        #2;
        arst_axi = 1'b0;
        #1;
        check("t5_rst_req", 64'(pkt_out_req), 64'h0);
        check("t5_rst_ready", 64'(in_ready), 64'h1);
        check("t5_rst_err", 64'(seq_err), 64'h0);
        @(negedge clk_axi);
        arst_axi = 1'b1;
        send(1'b0, 8'd2, 1'b1, 32'h50);
        chk_out("t5_head", flit(1'b1, 1'b0, 8'd2, 32'h50, 1'b1));
        send(1'b0, 8'd2, 1'b0, 32'h51);
        chk_out("t5_tail", flit(1'b0, 1'b1, 8'd2, 32'h51, 1'b1));

        // in_first on 2nd beat of a sz=4 packet
        send(1'b1, 8'd4, 1'b0, 32'h60);
        chk_out("t6_head", flit(1'b1, 1'b0, 8'd4, 32'h60, 1'b0));
        check("t6_err0", 64'(seq_err), 64'h0);
        send(1'b1, 8'd2, 1'b1, 32'h61);
`ifdef PKT_TX_SEQ_ERR_CHK_EN
        chk_out("t6_restart", flit(1'b1, 1'b0, 8'd2, 32'h61, 1'b1));
        check("t6_err1", 64'(seq_err), 64'h1);
        send(1'b0, 8'd4, 1'b0, 32'h62);
        chk_out("t6_tail", flit(1'b0, 1'b1, 8'd2, 32'h62, 1'b1));
        check("t6_err_pulse", 64'(seq_err), 64'h0);
`else
        chk_out("t6_body", flit(1'b0, 1'b0, 8'd4, 32'h61, 1'b0));
        check("t6_err1", 64'(seq_err), 64'h0);
        send(1'b0, 8'd4, 1'b1, 32'h62);
        chk_out("t6_b62", flit(1'b0, 1'b0, 8'd4, 32'h62, 1'b0));
        send(1'b0, 8'd4, 1'b1, 32'h63);
        chk_out("t6_tail", flit(1'b0, 1'b1, 8'd4, 32'h63, 1'b0));
`endif
        in_valid = 1'b0;
        tick();
        check("end_valid", 64'(pkt_out_req.valid), 64'h0);
        check("end_err", 64'(seq_err), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pkt_tx_seq.md
PKT_TX_SEQ -- requirements
Module: pkt_tx_seq

Interface
REQ-001 SHALL have parameter FLIT_DATA, default 32, payload bits per flit.
REQ-002 SHALL have parameter PKT_WIDTH, default 8, packet-size field width in flits.
REQ-003 SHALL have parameter NUM_VC, default 2, virtual channels; VC_W = max(1, $clog2(NUM_VC)).
REQ-004 SHALL have port clk_axi  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port arst_axi  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream beat valid.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data  input  FLIT_DATA  flit payload.
REQ-009 SHALL have port in_first  input  1  beat starts a new packet.
REQ-010 SHALL have port in_pkt_sz  input  PKT_WIDTH  total flits incl. head; sampled on head beat only.
REQ-011 SHALL have port in_vc  input  VC_W  target VC; sampled on head beat only.
REQ-012 SHALL have port pkt_out_req  output  s_pkt_out_req_t  fields valid, req_new, req_last, pkt_sz, flit_data, vc_id to packet processor.
REQ-013 SHALL have port pkt_out_resp  input  s_pkt_out_resp_t  field ready from packet processor.
REQ-014 SHALL have port seq_err  output  1  protocol-error pulse (see Configuration).

Function
REQ-015 SHALL register all pkt_out_req fields in a single output stage; latency from accepted beat to pkt_out_req.valid = 1 cycle.
REQ-016 SHALL drive in_ready = !pkt_out_req.valid || pkt_out_resp.ready (full-throughput pipeline, no bubble on back-to-back beats).
REQ-017 SHALL hold every pkt_out_req field stable while valid && !ready.
REQ-018 SHALL implement FSM IDLE/BODY; IDLE: accepted beat is head regardless of in_first.
REQ-019 SHALL on head: load rem = eff_sz-1, eff_sz = (in_pkt_sz==0) ? 1 : in_pkt_sz; latch vc and eff_sz; emit req_new=1, pkt_sz=eff_sz.
REQ-020 SHALL on head with eff_sz==1 emit req_new=1 and req_last=1 and remain in IDLE; otherwise go BODY.
REQ-021 SHALL in BODY emit req_new=0, latched vc/pkt_sz, decrement rem per accepted beat; req_last=1 when rem==1, then return to IDLE.
REQ-022 SHALL ignore in_vc and in_pkt_sz in BODY.
REQ-023 SHALL accept a new head in the same cycle the previous tail drains (tail out and head in simultaneously).
REQ-024 SHALL count with PKT_WIDTH-bit unsigned rem; no wrap (max size 2^PKT_WIDTH-1 flits).

Reset
REQ-025 SHALL on arst_axi low immediately force: FSM IDLE, rem 0, pkt_out_req all-zero (valid 0), seq_err 0; in_ready then 1.
REQ-026 SHALL discard any partial packet on reset mid-packet; next accepted beat after release is a head.

Configuration
REQ-027 SHALL use macro PKT_TX_SEQ_ERR_CHK_EN: when defined, in_first=1 accepted in BODY pulses seq_err for 1 cycle, terminates current packet (that beat is treated as new head per REQ-019, no tail emitted for the truncated packet); when undefined, in_first ignored in BODY and seq_err tied 0.

Verification
REQ-028 SHALL cover: head sz=3 vc=1 data A,B,C, ready=1 -> 3 consecutive outputs (new=1,last=0),(0,0),(0,1), all vc=1 pkt_sz=3.
REQ-029 SHALL cover: sz=1 -> single output req_new=1 req_last=1; sz=0 -> same, pkt_sz=1.
REQ-030 SHALL cover: ready=0 for 4 cycles mid-packet -> output fields stable, in_ready=0, no beat lost or duplicated.
REQ-031 SHALL cover: packet sz=2 followed immediately by sz=2 with ready=1 -> 4 flits in 4 cycles, head of second in cycle after first tail.
REQ-032 SHALL cover: arst_axi low after 2nd of 4 flits -> outputs zero asynchronously; next beat after release emitted as head.
REQ-033 SHALL cover with PKT_TX_SEQ_ERR_CHK_EN: in_first=1 on 2nd beat of sz=4 packet -> seq_err=1 one cycle, that beat emitted req_new=1; without macro -> emitted as body, seq_err=0.
